assoc_cache_ctrl: RTL and testbench
===================================

// Module: assoc_cache_ctrl
// PURPOSE
//  Parametrised N-way set-associative, single-word-line cache with a blocking miss FSM.
//  Sits between a core load/store port and a slower memory (BSRAM or the next cache level).
//  Write-through, no-write-allocate, with round-robin replacement.
//  Keeps hit/miss counters and prints them on report.
// PARAMETERS
//  CORE        0   core id printed in the report line
//  DATA_WIDTH  32  word width in bits
//  ADDR_WIDTH  8   word address width in bits
//  NUM_SETS    4   sets; power of 2, >=2
//  NUM_WAYS    2   ways per set; 1..4 (1 = direct-mapped)
// PORTS
//  clk            in   1           clock, rising edge
//  rst            in   1           asynchronous reset, active high
//  report         in   1           print stats (simulation only)
//  req_valid      in   1           core request valid
//  req_ready      out  1           controller can accept a request
//  req_write      in   1           1 = store, 0 = load
//  req_addr       in   ADDR_WIDTH  word address
//  req_wdata      in   DATA_WIDTH  store data
//  resp_valid     out  1           one-cycle response pulse
//  resp_rdata     out  DATA_WIDTH  load data; 0 for stores
//  resp_hit       out  1           request hit in cache
//  mem_req        out  1           memory request; held until mem_resp_valid
//  mem_write      out  1           memory request is a write
//  mem_addr       out  ADDR_WIDTH  memory address
//  mem_wdata      out  DATA_WIDTH  memory write data
//  mem_resp_valid in   1           memory completion (read data or write ack)
//  mem_rdata      in   DATA_WIDTH  memory read data
//  hit_count      out  32          saturating hit counter
//  miss_count     out  32          saturating miss counter
// BEHAVIOUR
//  Reset (async): state IDLE; all valid bits, replacement pointers and counters = 0.
//   All outputs 0 except req_ready = 1. Tag/data arrays are not cleared.
//  Address split: index = req_addr[log2(NUM_SETS)-1:0]; tag = remaining upper bits.
//  FSM states: IDLE, LOOKUP, MEM_WAIT, RESPOND.
//  IDLE: req_ready = 1. On req_valid, register write/addr/wdata -> LOOKUP.
//   req_ready = 0 in every other state; the requester holds its request.
//  LOOKUP: compare the tag in all ways of the set (at most one way matches).
//   Read hit: resp_valid=1, resp_hit=1, resp_rdata=way data -> IDLE.
//    Latency is 1 cycle after acceptance. hit_count += 1.
//   Read miss: miss_count += 1; mem_req=1, mem_write=0, mem_addr=addr -> MEM_WAIT.
//   Write hit: update the way data; hit_count += 1; mem_req=1, mem_write=1 -> MEM_WAIT.
//   Write miss: miss_count += 1; no allocation; mem_req=1, mem_write=1 -> MEM_WAIT.
//  MEM_WAIT: mem_* outputs stable until mem_resp_valid, then drop mem_req the same cycle.
//   Read: fill the victim way (tag, data, valid=1), latch mem_rdata.
//   Both read and write then go to RESPOND.
//  RESPOND: resp_valid=1 for one cycle; resp_hit = hit result from LOOKUP.
//   resp_rdata = filled data for a read, 0 for a write. Then -> IDLE.
//  Victim selection: lowest-index invalid way; if none, the set's round-robin pointer.
//   The pointer advances (mod NUM_WAYS) only on a fill that evicts a valid line.
//  mem_resp_valid outside MEM_WAIT is ignored.
//  Counters saturate at 32'hFFFF_FFFF; they never wrap.
//  report high on a clk edge: $display "core CORE hits H misses M" once per edge.
//  Reset mid-miss: mem_req drops immediately. Any late mem_resp_valid is ignored (state IDLE).
//  Minimum miss latency: acceptance -> LOOKUP -> MEM_WAIT (>=1) -> RESPOND = 3 cycles.
// STRUCTURE
//  Shared include cache_defs.vh holds:
//   state encodings (IDLE=2'd0, LOOKUP=2'd1, MEM_WAIT=2'd2, RESPOND=2'd3);
//   the clog2 helper function;
//   the counter width constant (32).
//  Sub-module cache_way: one way's tag/valid/data arrays.
//   Single read/write port; combinational tag compare; NUM_WAYS instances.
//  The FSM, victim selection and counters live in assoc_cache_ctrl.
// TESTING
//  1. Cold read of addr 0x05 with mem_rdata=0xDEADBEEF, mem responding after 2 cycles:
//     expect 1 mem_req, resp_hit=0, rdata=0xDEADBEEF, miss_count=1.
//  2. Reread 0x05: expect resp_valid 1 cycle after acceptance, hit=1, no mem_req, hit_count=1.
//  3. NUM_WAYS=2, NUM_SETS=4: read 0x01, 0x05, 0x09 (all set 1), then 0x01:
//     expect 0x01 evicted by 0x09 and the 4th access to miss (miss_count=4).
//  4. Write 0x05 = 0x12345678 after (1): mem_write=1 with that data, resp_hit=1;
//     a following read of 0x05 hits and returns 0x12345678.
//  5. Write-miss to 0x3C: mem write issued, resp_hit=0; a following read of 0x3C misses
//     (no allocation).
//  6. Assert rst during MEM_WAIT, then pulse mem_resp_valid:
//     expect mem_req=0, req_ready=1, counters=0, no resp_valid, and a reread of 0x05 misses.

Source files
------------

// File: rtl/assoc_cache_ctrl_pkg.sv
// Shared types and constants for the set-associative cache controller.
// Holds the FSM encoding, the counter width and a constant-safe log2 helper.
package assoc_cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    MEM_WAIT = 2'd2,
    RESPOND  = 2'd3
  } state_t;

  localparam int CNT_W = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/assoc_cache_ctrl_if.sv
// Core request/response and memory request/completion bundle for the cache controller.
// slave = controller view, master = the core/memory environment driving it.
interface assoc_cache_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_hit;
  logic                  mem_req;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_resp_valid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_resp_valid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/assoc_cache_ctrl_way.sv
// One cache way: per-set valid/tag/data with a combinational tag compare.
// Zero-latency read, write lands on the clock edge; valid bits reset, tag/data do not.
module cache_way #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 6,
  parameter int NUM_SETS   = 4,
  parameter int IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      index,
  input  logic [TAG_W-1:0]      lookup_tag,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  hit,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [NUM_SETS-1:0]   valid_q;
  logic [TAG_W-1:0]      tag_mem  [NUM_SETS];
  logic [DATA_WIDTH-1:0] data_mem [NUM_SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else if (we) valid_q[index] <= 1'b1;
  end

  // A write always carries the current lookup tag, so fills and write-hit updates share one port.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[index]  <= lookup_tag;
      data_mem[index] <= wdata;
    end
  end

  assign valid = valid_q[index];
  assign hit   = valid_q[index] && (tag_mem[index] == lookup_tag);
  assign rdata = data_mem[index];
endmodule

// File: rtl/assoc_cache_ctrl.sv
// N-way write-through, no-write-allocate cache with round-robin replacement and a blocking miss FSM.
// Read hit responds 1 cycle after acceptance, misses >= 3; req_ready only in IDLE, mem_req held until mem_resp_valid.
module assoc_cache_ctrl
  import assoc_cache_ctrl_pkg::*;
#(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_SETS   = 4,
  parameter int NUM_WAYS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             report,
  assoc_cache_ctrl_if.slave bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int IDX_W = clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? clog2(NUM_WAYS) : 1;

  state_t                state, state_nxt;
  logic                  wr_q, hit_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [WAY_W-1:0]      rr_ptr [NUM_SETS];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [NUM_WAYS-1:0]   way_hit, way_valid, way_we;
  logic [DATA_WIDTH-1:0] way_rdata [NUM_WAYS];
  logic [DATA_WIDTH-1:0] way_wdata, hit_data;
  logic [WAY_W-1:0]      victim;
  logic                  any_hit, victim_evicts, fill, read_hit;

  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_WIDTH-1:IDX_W];

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    cache_way #(
      .DATA_WIDTH(DATA_WIDTH), .TAG_W(TAG_W), .NUM_SETS(NUM_SETS), .IDX_W(IDX_W)
    ) u_way (
      .clk(clk), .rst(rst), .index(idx), .lookup_tag(tag),
      .we(way_we[w]), .wdata(way_wdata),
      .hit(way_hit[w]), .valid(way_valid[w]), .rdata(way_rdata[w])
    );
  end

  always_comb begin
    any_hit       = |way_hit;
    hit_data      = '0;
    victim        = rr_ptr[idx];
    victim_evicts = 1'b1;
    for (int w = 0; w < NUM_WAYS; w++)
      if (way_hit[w]) hit_data = way_rdata[w];
    // Descending scan so the lowest-index invalid way wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!way_valid[w]) begin
        victim        = WAY_W'(w);
        victim_evicts = 1'b0;
      end
    read_hit  = (state == LOOKUP) && !wr_q && any_hit;
    fill      = (state == MEM_WAIT) && bus.mem_resp_valid && !wr_q;
    way_wdata = fill ? bus.mem_rdata : wdata_q;
    for (int w = 0; w < NUM_WAYS; w++)
      way_we[w] = ((state == LOOKUP) && wr_q && way_hit[w]) || (fill && (victim == WAY_W'(w)));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.req_valid) state_nxt = LOOKUP;
      LOOKUP:   state_nxt = read_hit ? IDLE : MEM_WAIT;
      MEM_WAIT: if (bus.mem_resp_valid) state_nxt = RESPOND;
      RESPOND:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = read_hit || (state == RESPOND);
    bus.resp_hit   = read_hit || ((state == RESPOND) && hit_q);
    bus.resp_rdata = '0;
    if (read_hit) bus.resp_rdata = hit_data;
    else if ((state == RESPOND) && !wr_q) bus.resp_rdata = rdata_q;
    bus.mem_req   = (state == MEM_WAIT);
    bus.mem_write = (state == MEM_WAIT) && wr_q;
    bus.mem_addr  = (state == MEM_WAIT) ? addr_q : '0;
    bus.mem_wdata = ((state == MEM_WAIT) && wr_q) ? wdata_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      hit_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < NUM_SETS; s++) rr_ptr[s] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.req_valid) begin
        wr_q    <= bus.req_write;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == LOOKUP) begin
        hit_q <= any_hit;
        if (any_hit) begin
          if (hit_count != '1) hit_count <= hit_count + 1'b1;
        end else if (miss_count != '1) begin
          miss_count <= miss_count + 1'b1;
        end
      end
      if (fill) begin
        rdata_q <= bus.mem_rdata;
        if (victim_evicts)
          rr_ptr[idx] <= (32'(rr_ptr[idx]) == NUM_WAYS - 1) ? '0 : rr_ptr[idx] + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (report) $display("core %0d hits %0d misses %0d", CORE, hit_count, miss_count);
  end
`endif
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl (4 sets x 2 ways) with an inline memory responder.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_assoc_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        report = 1'b0;
  logic [31:0] hit_count, miss_count;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        r_hit, r_mw, r_again;
  logic [31:0] r_rdata, r_maddr, r_mwd;
  int          r_lat, r_nmem;

  always #5 clk = ~clk;

  assoc_cache_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  assoc_cache_ctrl #(
    .CORE(0), .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_SETS(4), .NUM_WAYS(2)
  ) dut (
    .clk(clk), .rst(rst), .report(report), .bus(bus),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One core access; memory answers after mem_req has been seen for 'delay' cycles.
  task automatic access(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mdata, input int delay);
    int   seen;
    logic prev_req, done;
    r_hit = 0; r_rdata = '0; r_lat = 0; r_nmem = 0; r_mw = 0; r_maddr = '0; r_mwd = '0;
    r_again = 0; seen = 0; prev_req = 0; done = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.mem_rdata = mdata;
    @(posedge clk);
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (bus.mem_req) begin
        if (!prev_req) begin
          r_nmem++;
          r_mw = bus.mem_write; r_maddr = 32'(bus.mem_addr); r_mwd = bus.mem_wdata;
        end
        seen++;
        if (seen == delay) bus.mem_resp_valid = 1'b1;
      end
      prev_req = bus.mem_req;
      if (bus.resp_valid) begin
        r_hit = bus.resp_hit; r_rdata = bus.resp_rdata; r_lat = c; done = 1;
      end
    end
    if (!done) check("resp_timeout", 32'd0, 32'd1);
    else begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      r_again = bus.resp_valid;
    end
  endtask

  initial begin
    int resp_seen;
    logic got_req;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_resp_valid = 0; bus.mem_rdata = '0;
    do_reset();

    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);

    // Replacement in set 1: 0x01 -> way0, 0x05 -> way1, 0x09 evicts 0x01, 0x01 evicts 0x05.
    access(1'b0, 8'h01, '0, 32'h0000_0011, 1);
    check("rr_a_hit", 32'(r_hit), 32'd0);
    check("rr_a_lat", r_lat, 32'd3);
    access(1'b0, 8'h05, '0, 32'h0000_0055, 1);
    access(1'b0, 8'h09, '0, 32'h0000_0099, 1);
    check("rr_c_hit", 32'(r_hit), 32'd0);
    access(1'b0, 8'h01, '0, 32'h0000_1111, 1);
    check("rr_d_hit", 32'(r_hit), 32'd0);
    check("rr_d_nmem", r_nmem, 32'd1);
    check("rr_misses", miss_count, 32'd4);
    access(1'b0, 8'h09, '0, 32'hFFFF_FFFF, 1);
    check("rr_09_hit", 32'(r_hit), 32'd1);
    check("rr_09_data", r_rdata, 32'h0000_0099);
    access(1'b0, 8'h01, '0, 32'hFFFF_FFFF, 1);
    check("rr_01_data", r_rdata, 32'h0000_1111);
    check("rr_hits", hit_count, 32'd2);

    do_reset();
    @(negedge clk);
    check("rst2_hits", hit_count, 32'd0);

    // Cold read, memory answers after 2 cycles.
    access(1'b0, 8'h05, '0, 32'hDEAD_BEEF, 2);
    check("cold_nmem", r_nmem, 32'd1);
    check("cold_mem_write", 32'(r_mw), 32'd0);
    check("cold_mem_addr", r_maddr, 32'h05);
    check("cold_hit", 32'(r_hit), 32'd0);
    check("cold_rdata", r_rdata, 32'hDEAD_BEEF);
    check("cold_lat", r_lat, 32'd4);
    check("cold_one_pulse", 32'(r_again), 32'd0);
    check("cold_misses", miss_count, 32'd1);

    access(1'b0, 8'h05, '0, 32'h0, 1);
    check("reread_lat", r_lat, 32'd1);
    check("reread_hit", 32'(r_hit), 32'd1);
    check("reread_nmem", r_nmem, 32'd0);
    check("reread_rdata", r_rdata, 32'hDEAD_BEEF);
    check("reread_hits", hit_count, 32'd1);

    // Write hit goes through to memory and updates the cached word.
    access(1'b1, 8'h05, 32'h1234_5678, 32'h0, 1);
    check("wh_mem_write", 32'(r_mw), 32'd1);
    check("wh_mem_wdata", r_mwd, 32'h1234_5678);
    check("wh_hit", 32'(r_hit), 32'd1);
    check("wh_rdata", r_rdata, 32'd0);
    access(1'b0, 8'h05, '0, 32'h0, 1);
    check("wh_rd_hit", 32'(r_hit), 32'd1);
    check("wh_rd_data", r_rdata, 32'h1234_5678);
    check("wh_hits", hit_count, 32'd3);

    // Write miss does not allocate.
    access(1'b1, 8'h3C, 32'hCAFE_0001, 32'h0, 1);
    check("wm_mem_write", 32'(r_mw), 32'd1);
    check("wm_mem_addr", r_maddr, 32'h3C);
    check("wm_hit", 32'(r_hit), 32'd0);
    access(1'b0, 8'h3C, '0, 32'hAAAA_5555, 1);
    check("wm_rd_hit", 32'(r_hit), 32'd0);
    check("wm_rd_nmem", r_nmem, 32'd1);
    check("wm_rd_data", r_rdata, 32'hAAAA_5555);
    check("wm_misses", miss_count, 32'd3);

    // Reset while the controller waits on memory.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'h21;
    @(posedge clk);
    got_req = 1'b0;
    for (int c = 0; c < 10 && !got_req; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      got_req = bus.mem_req;
    end
    check("mid_mem_req", 32'(got_req), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_hits", hit_count, 32'd0);
    check("mid_rst_misses", miss_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    resp_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.resp_valid) resp_seen++;
      bus.mem_resp_valid = (c == 0);
    end
    check("late_resp_valid", resp_seen, 32'd0);
    check("late_mem_req", 32'(bus.mem_req), 32'd0);
    check("late_ready", 32'(bus.req_ready), 32'd1);
    access(1'b0, 8'h05, '0, 32'h0BAD_F00D, 1);
    check("post_rst_hit", 32'(r_hit), 32'd0);
    check("post_rst_rdata", r_rdata, 32'h0BAD_F00D);
    check("post_rst_misses", miss_count, 32'd1);

    @(negedge clk);
    report = 1'b1;
    @(negedge clk);
    report = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
